// File: rtl/meas_sample_sched.sv
`default_nettype none
// ============================================================================
// Module      : meas_sample_sched
// Description : Cycle-accurate sample scheduler with a capture FIFO. When it
//               is armed by en, it captures din_p - din_n at programmed cycle
//               offsets. Each capture is either a single sample at T_START or
//               one sample every T_INT cycles up to T_END. Every capture is
//               stamped with its offset and is streamed out as a
//               (timestamp, difference) pair over a first-word-fall-through
//               valid/ready interface.
// Ports       : clk        - sampling clock, rising edge
//               rstn       - asynchronous active-low reset
//               en         - arm/hold level; low aborts and flushes
//               din_p/n    - signed input legs, DW bits
//               out_valid  - FIFO head holds a pair
//               out_ready  - consumer accepts the head
//               out_time   - head timestamp (cycle offset from arm)
//               out_diff   - head difference, DW+1 bits signed
//               win_active - sampling window open
//               done       - run finished and FIFO drained
//               overflow   - sticky sample-dropped flag
//               level      - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module meas_sample_sched #(
    parameter int unsigned DW      = 16,
    parameter int unsigned TW      = 32,
    parameter int unsigned T_START = 0,
    parameter int unsigned T_END   = 0,
    parameter int unsigned T_INT   = 1,
    parameter int unsigned WINDOW  = 0,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [DW-1:0]            din_p,
    input  logic [DW-1:0]            din_n,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TW-1:0]            out_time,
    output logic [DW:0]              out_diff,
    output logic                     win_active,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Schedule constants are held one bit wider than the counter, so that
    // "next offset > T_END" can be evaluated without wrapping.
    localparam logic [TW:0]   c_start   = (TW+1)'(T_START);
    localparam logic [TW:0]   c_end     = (TW+1)'(T_END);
    localparam logic [TW:0]   c_int     = (T_INT == 0) ? (TW+1)'(1) : (TW+1)'(T_INT);
    localparam logic [TW:0]   c_one_ext = (TW+1)'(1);
    localparam logic [TW-1:0] c_one_cnt = TW'(1);
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_one_lvl = (AW+1)'(1);
    localparam logic [AW-1:0] c_one_ptr = AW'(1);
    // A window that closes before it opens collapses to a single capture.
    localparam logic          c_single  = (WINDOW == 0) || (T_END < T_START);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SAMPLE = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_cnt;
    logic [TW:0]     r_next;      // offset of the next scheduled capture
    logic            r_win;
    logic            r_done;
    logic            r_ovf;

    logic [TW-1:0]   r_mem_time [DEPTH];
    logic [DW:0]     r_mem_diff [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_level;

    logic [TW:0]     w_cnt_ext;
    logic [TW-1:0]   w_cnt_inc;
    logic [TW:0]     w_next_cap;
    logic            w_capture;
    logic            w_last;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_flush;
    logic            w_arm;
    logic [DW:0]     w_diff;

    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + c_one_cnt;
    assign w_next_cap = r_next + c_int;
    assign w_capture  = en && (r_state == S_SAMPLE) && (w_cnt_ext == r_next);
    assign w_last     = c_single || (w_next_cap > c_end);

    // Both legs are sign-extended by one bit, so the difference always fits.
    assign w_diff     = {din_p[DW-1], din_p} - {din_n[DW-1], din_n};

    assign out_valid  = (r_level != '0);
    assign w_full     = (r_level == c_depth);
    assign w_pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot a capture into a full FIFO needs.
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;
    assign w_flush    = !en || (r_state == S_IDLE);
    assign w_arm      = en && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Scheduler state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_next  <= '0;
            r_win   <= 1'b0;
            r_done  <= 1'b0;
        end else if (!en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_win   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_next <= c_start;
                    r_done <= 1'b0;
                    if (c_start == '0) begin
                        r_state <= S_SAMPLE;
                        r_win   <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // Enter SAMPLE one edge early so that win_active is
                    // already high in the T_START cycle.
                    if (w_cnt_ext + c_one_ext == c_start) begin
                        r_state <= S_SAMPLE;
                        r_win   <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_capture) begin
                        r_next <= w_next_cap;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_win   <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_cnt <= w_cnt_inc;
                    if (r_level == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_cnt <= w_cnt_inc;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO control (pointers, occupancy, overflow)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (w_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            // Overflow survives an abort and is cleared only by a new arm.
            if (w_arm) begin
                r_ovf <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_one_ptr;
            end
            if (w_pop) begin
                r_rd <= r_rd + c_one_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_one_lvl;
                2'b01:   r_level <= r_level - c_one_lvl;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever level is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_time[r_wr] <= r_cnt;
            r_mem_diff[r_wr] <= w_diff;
        end
    end

    assign out_time   = out_valid ? r_mem_time[r_rd] : '0;
    assign out_diff   = out_valid ? r_mem_diff[r_rd] : '0;
    assign win_active = r_win;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign level      = r_level;

endmodule
`default_nettype wire

// File: doc/meas_sample_sched.md
# meas_sample_sched

Clocked sample scheduler and capture buffer that sits directly upstream of the differential dump stage in the measurement library. After it is armed, it captures the difference of two signed input words at programmed cycle offsets, either once or over a periodic window. Each capture is stamped with its cycle offset, and the block streams the resulting (timestamp, difference) pairs to the logger through a buffered valid/ready interface. It replaces free-running event scheduling with a deterministic, cycle-accurate one that tolerates backpressure from the consumer.

## Interface
Parameters:
- DW, 16: width of each signed input word.
- TW, 32: width of the cycle counter and timestamp.
- T_START, 0: cycle offset of the first sample, counted from arm.
- T_END, 0: last allowed sample offset (window mode only).
- T_INT, 1: sample interval in cycles (window mode only); 0 is treated as 1.
- WINDOW, 0: 0 = single sample at T_START; 1 = samples at T_START + k*T_INT while ≤ T_END.
- DEPTH, 8: FIFO depth; must be a power of two, ≥ 2.

Ports:
- clk  in  1  sampling clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  arm/hold level; going low aborts the run from any state.
- din_p  in  DW  signed positive-leg word.
- din_n  in  DW  signed negative-leg word.
- out_valid  out  1  FIFO head holds a valid pair.
- out_ready  in  1  consumer accepts the head this cycle.
- out_time  out  TW  timestamp (cycle offset) of the head.
- out_diff  out  DW+1  signed head value, din_p − din_n.
- win_active  out  1  high while the sampling window is open.
- done  out  1  run complete and FIFO drained.
- overflow  out  1  sticky: at least one sample was dropped.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- The state machine has five states: IDLE, WAIT, SAMPLE, DRAIN, DONE.
- IDLE → WAIT when en = 1. On this arm cycle: cnt ← 0, overflow ← 0, FIFO emptied.
- cnt increments by 1 every cycle outside IDLE and saturates at 2^TW − 1.
- WAIT → SAMPLE when cnt == T_START. The capture at T_START is taken in that same cycle.
- In SAMPLE, captures occur when cnt == T_START + k*T_INT, for integer k ≥ 0, and cnt ≤ T_END.
- Single mode (WINDOW = 0), or window mode with T_END < T_START: exactly one capture, at T_START.
- SAMPLE → DRAIN in the cycle of the last capture. The last capture is the only capture in single mode; in window mode it is the last one with next offset > T_END.
- DRAIN → DONE when the FIFO is empty.
- DONE → IDLE when en = 0.
- en = 0 in any state: next state is IDLE, the FIFO is flushed, and out_valid = 0 on the next cycle.
- A capture pushes {cnt, sign-extended din_p − sign-extended din_n}. The subtraction is done at DW+1 bits and never wraps.
- If the FIFO is full at capture and no pop happens in the same cycle, the sample is dropped and overflow ← 1.
- Push and pop in the same cycle while full: both occur, no overflow, level is unchanged.
- The FIFO is first-word-fall-through. out_valid = (level ≠ 0). A pop occurs when out_valid && out_ready.
- While out_valid && !out_ready, out_time and out_diff hold stable.
- win_active = 1 from the T_START cycle through the last-capture cycle inclusive.

## Timing
- Reset values: state IDLE, cnt 0, out_valid 0, out_time 0, out_diff 0, win_active 0, done 0, overflow 0, level 0.
- A capture at offset N (counted from the arm cycle, N = 0) samples din on the clk edge ending that cycle.
- The pushed pair appears at the FIFO head one cycle later. If the FIFO was empty, out_valid rises in cycle N + 1.
- level updates one cycle after the push or pop.
- done is registered: it rises the cycle after DRAIN sees an empty FIFO, and falls the cycle after en = 0.
- Asserting rstn low mid-run forces every output to its reset value immediately, without waiting for a clock edge.

## Test plan
- Single mode, T_START = 5, din_p = 100, din_n = −20, out_ready = 1: one pair (5, 120) with out_valid high in cycle 6; done rises afterwards; no further pairs.
- Window mode, T_START = 2, T_INT = 3, T_END = 11, out_ready = 1: pairs at times 2, 5, 8, 11; win_active is high for cycles 2–11; done = 1 after the fourth pair.
- Same window with DEPTH = 2 and out_ready = 0 throughout: the first two pairs are kept and the rest dropped; overflow = 1, level = 2. Raising out_ready then drains (2, …) and (5, …).
- Extreme values DW = 16, din_p = 32767, din_n = −32768: out_diff = 65535 in 17-bit signed, no wrap. The reversed inputs give −65535.
- Abort: en dropped at cycle 6 of a window run with 2 entries buffered: the next cycle is IDLE with out_valid = 0 and level = 0. Re-arming restarts cnt at 0 and clears overflow.
- rstn pulsed low mid-DRAIN: all outputs go to their reset values immediately; after release with en = 1, a fresh run starts from cnt = 0.
